// File: rtl/siso_seq_ctrl.sv
// Fill / run / drain sequencer for the SISO shift register: drives the Gray
// write pointer, one-hot stage-load strobes and the output-valid flag.
module siso_seq_ctrl #(
    parameter int STAGES_LOG2 = 3
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          EN,
    input  logic                          START,
    input  logic                          STOP,
    output logic [STAGES_LOG2-1:0]        GRAY,
    output logic [(1<<STAGES_LOG2)-1:0]   PULSES,
    output logic                          PHASE_WRAP,
    output logic                          VALID_OUT,
    output logic [1:0]                    STATE
);

    localparam int DEPTH = 1 << STAGES_LOG2;
    localparam int OW    = STAGES_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [STAGES_LOG2-1:0] ptr_q, ptr_d, ptr_inc;
    logic [OW-1:0]          occ_q, occ_d;
    logic [STAGES_LOG2-1:0] gray_d;
    logic [DEPTH-1:0]       pulses_d, pulse_one;
    logic                   wrap_d, valid_d;
    logic                   advance, last_fill, last_drain;

    assign advance    = EN && (state_q != IDLE);
    assign ptr_inc    = ptr_q + 1'b1;
    assign last_fill  = (occ_q == OW'(DEPTH - 1));
    assign last_drain = (occ_q == OW'(1));
    assign pulse_one  = {{(DEPTH-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; STOP in FILL beats the final fill advance
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (START) state_d = FILL;
            FILL: begin
                if (STOP)                   state_d = IDLE;
                else if (EN && last_fill)   state_d = RUN;
            end
            RUN:   if (STOP) state_d = DRAIN;
            DRAIN: if (EN && last_drain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ptr_d    = ptr_q;
        occ_d    = occ_q;
        gray_d   = GRAY;
        pulses_d = '0;
        wrap_d   = 1'b0;
        valid_d  = VALID_OUT;

        if (advance) begin
            pulses_d = pulse_one << ptr_q;
            ptr_d    = ptr_inc;
            gray_d   = ptr_inc ^ (ptr_inc >> 1);
            wrap_d   = (ptr_q == '1);
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    ptr_d  = '0;
                    occ_d  = '0;
                    gray_d = '0;
                end
            end
            FILL: begin
                if (STOP) begin
                    pulses_d = '0;
                    wrap_d   = 1'b0;
                    ptr_d    = '0;
                    gray_d   = '0;
                    occ_d    = '0;
                end else if (EN) begin
                    occ_d = occ_q + 1'b1;
                    if (last_fill) valid_d = 1'b1;
                end
            end
            RUN: ;
            DRAIN: begin
                // Final drain advance still emits its strobe before returning home
                if (EN) begin
                    occ_d = occ_q - 1'b1;
                    if (last_drain) begin
                        ptr_d   = '0;
                        gray_d  = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q      <= '0;
            occ_q      <= '0;
            GRAY       <= '0;
            PULSES     <= '0;
            PHASE_WRAP <= 1'b0;
            VALID_OUT  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            occ_q      <= occ_d;
            GRAY       <= gray_d;
            PULSES     <= pulses_d;
            PHASE_WRAP <= wrap_d;
            VALID_OUT  <= valid_d;
        end
    end

    assign STATE = state_q;

    a_pulses_onehot0: assert property (@(posedge CLK) disable iff (!RESET) $onehot0(PULSES));
    a_occ_range:      assert property (@(posedge CLK) disable iff (!RESET) occ_q <= OW'(DEPTH));

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Randomized + directed scoreboard bench for siso_seq_ctrl against a
// behavioural model of the fill / run / drain sequencing rules.
module tb_siso_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       EN = 1'b0, START = 1'b0, STOP = 1'b0;
    logic [2:0] GRAY;
    logic [7:0] PULSES;
    logic       PHASE_WRAP, VALID_OUT;
    logic [1:0] STATE;

    siso_seq_ctrl #(.STAGES_LOG2(3)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .STOP(STOP),
        .GRAY(GRAY), .PULSES(PULSES), .PHASE_WRAP(PHASE_WRAP),
        .VALID_OUT(VALID_OUT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] gray;
        logic [7:0] pulses;
        logic       wrap;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 idle, 1 filling, 2 running, 3 draining
    int   m_mode, m_ptr, m_occ;
    logic m_valid;
    int   gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_occ = 0; m_valid = 1'b0;
    endtask

    // Apply one edge worth of inputs to the model and queue the expected outputs
    task automatic step(input logic en, input logic start, input logic stop);
        exp_t e;
        int   pls, wrp;
        @(negedge CLK);
        EN = en; START = start; STOP = stop;
        pls = 0; wrp = 0;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_ptr = 0; m_occ = 0; end
            1: begin
                if (stop) begin
                    m_mode = 0; m_ptr = 0; m_occ = 0;
                end else if (en) begin
                    pls = 1 << m_ptr; wrp = (m_ptr == 7);
                    m_ptr = (m_ptr + 1) % 8;
                    m_occ++;
                    if (m_occ == 8) begin m_mode = 2; m_valid = 1'b1; end
                end
            end
            2: begin
                if (en) begin
                    pls = 1 << m_ptr; wrp = (m_ptr == 7);
                    m_ptr = (m_ptr + 1) % 8;
                end
                if (stop) m_mode = 3;
            end
            default: begin
                if (en) begin
                    pls = 1 << m_ptr; wrp = (m_ptr == 7);
                    m_ptr = (m_ptr + 1) % 8;
                    m_occ--;
                    if (m_occ == 0) begin m_mode = 0; m_ptr = 0; m_valid = 1'b0; end
                end
            end
        endcase
        e.st     = 2'(m_mode);
        e.gray   = 3'(gray_tab[m_ptr]);
        e.pulses = 8'(pls);
        e.wrap   = (wrp != 0);
        e.valid  = m_valid;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("STATE",      32'(STATE),      32'(e.st));
                chk("GRAY",       32'(GRAY),       32'(e.gray));
                chk("PULSES",     32'(PULSES),     32'(e.pulses));
                chk("PHASE_WRAP", 32'(PHASE_WRAP), 32'(e.wrap));
                chk("VALID_OUT",  32'(VALID_OUT),  32'(e.valid));
            end
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_STATE"},  32'(STATE),      0);
        chk({tag, "_GRAY"},   32'(GRAY),       0);
        chk({tag, "_PULSES"}, 32'(PULSES),     0);
        chk({tag, "_WRAP"},   32'(PHASE_WRAP), 0);
        chk({tag, "_VALID"},  32'(VALID_OUT),  0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        #1 chk_cleared("rst_release");
    endtask

    initial begin
        model_reset();
        // Reset held with random inputs
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            EN = 1'($urandom); START = 1'($urandom); STOP = 1'($urandom);
        end
        chk_cleared("rst_hold");
        EN = 0; START = 0; STOP = 0;
        release_reset();

        // Full cycle with EN constant
        step(1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        // Advance to ptr=3, then drain with a START and STOP collision inside
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        step(1, 0, 1);
        step(1, 1, 0);
        step(1, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Throttled fill then STOP from RUN with EN low, drain with EN toggling
        step(0, 1, 0);
        for (int i = 0; i < 16; i++) step(1'(i % 2 == 0), 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 18; i++) step(1'(i % 2 == 1), 0, 0);

        // Fill abort on the 5th advance
        step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);

        // START+STOP together in IDLE, abort on the final fill advance
        step(1, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);

        // Async reset in RUN between edges
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1 chk_cleared("rst_async");
        EN = 0; START = 0; STOP = 0;
        repeat (2) @(posedge CLK);
        release_reset();

        // Random phase
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
                 1'($urandom_range(0, 19) < 1));
        step(0, 0, 0);

        @(posedge CLK);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
